uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Serial transmitter with a small input FIFO. Frames: 1 start bit (low), 8 data bits LSB first,
//   1 stop bit (high); line idles high. Sits between on-chip producers (ADC sample formatter,
//   command responder) and the host serial line, decoupling bursty writes from the bit rate.
// PARAMETERS
//   TICKS_PER_CYCLE  48  bit period = TICKS_PER_CYCLE+1 clocks (counter reloads N, counts to 0)
//   FIFO_DEPTH       4   FIFO entries; power of two, >= 2
// PORTS
//   clock        in   1              system clock; all logic on posedge
//   reset        in   1              asynchronous, active-high
//   data         in   8              byte to enqueue
//   dataValid    in   1              producer offers data this cycle
//   readyForData out  1              FIFO can accept; write occurs when dataValid && readyForData
//   serialOut    out  1              TX line, registered
//   busy         out  1              frame in progress or FIFO non-empty
//   fifoCount    out  $clog2(FIFO_DEPTH+1)  entries held
// BEHAVIOUR
//   Reset (async, applies immediately): serialOut=1, busy=0, fifoCount=0, readyForData=1,
//     FSM=IDLE, FIFO pointers 0, bit counter 0, tick counter 0. Frame in flight is truncated.
//   FIFO: readyForData = (fifoCount != FIFO_DEPTH), from registered count only.
//     Push and pop in the same cycle: count unchanged, both succeed. Push when full: ignored,
//     no state change. Pointers wrap modulo FIFO_DEPTH.
//   FSM states / transitions (tick counter T, bit index B):
//     IDLE : serialOut=1. If fifoCount!=0: pop head into shift reg, serialOut<=0, T<=TICKS_PER_CYCLE,
//            -> START. Start bit falls on edge after the accepting edge (1-clock latency).
//     START: T!=0: T<=T-1. T==0: serialOut<=shift[0], shift>>1, B<=7, T<=TICKS_PER_CYCLE -> DATA.
//     DATA : T!=0: T<=T-1. T==0: if B!=0 drive next bit, B<=B-1, reload T; if B==0 serialOut<=1,
//            reload T -> STOP.
//     STOP : T!=0: T<=T-1. T==0: if fifoCount!=0 pop and start next frame exactly as IDLE does
//            (no extra idle bit between frames); else -> IDLE.
//   Every bit (start, 8 data, stop) holds exactly TICKS_PER_CYCLE+1 clocks; frame = 10 periods.
//   busy = (FSM != IDLE) || (fifoCount != 0); low only when line idle and FIFO empty.
//   dataValid is ignored while readyForData=0; producer must hold data/dataValid until accepted.
//   data sampled only on the accepting edge; later changes never affect queued bytes.
//   No glitches: serialOut only changes on bit boundaries.
// TESTING
//   TICKS_PER_CYCLE=3, write 0x55 from idle -> serialOut low 1 clock after accept, then
//     bits 1,0,1,0,1,0,1,0, stop high, each exactly 4 clocks; busy falls after stop period.
//   Write 0xA5 then 0x3C on consecutive cycles -> two frames back to back, second start bit
//     immediately after first stop period (40 clocks apart), decoded bytes 0xA5, 0x3C.
//   FIFO_DEPTH=4, hold dataValid with 6 distinct bytes -> 5 accepted (first popped at once),
//     readyForData=0 and fifoCount=4 until first frame ends; all bytes sent in order.
//   Push and pop on same edge at fifoCount=4 is impossible (ready=0); at fifoCount=2 with
//     a pop -> fifoCount stays 2.
//   Assert reset mid-data-bit -> serialOut=1 in same cycle, fifoCount=0, busy=0; next write
//     0x0F after release sends a clean full frame.
//   Random bytes with random dataValid gaps, line decoded by a bench receiver sampling at
//     mid-bit -> byte stream matches accepted sequence, no framing errors.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 serial transmitter fed by a small byte FIFO
module uart_tx_fifo #(
  parameter int TICKS_PER_CYCLE = 48,
  parameter int FIFO_DEPTH      = 4,
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             dataValid,
  output logic             readyForData,
  output logic             serialOut,
  output logic             busy,
  output logic [CNT_W-1:0] fifoCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TICKS_PER_CYCLE > 0) ? $clog2(TICKS_PER_CYCLE + 1) : 1;
  localparam logic [TW-1:0]    TICK_RELOAD = TW'(TICKS_PER_CYCLE);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  logic [TW-1:0]    r_tick;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_serial;

  state_t           w_state_nxt;
  logic [TW-1:0]    w_tick_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_serial_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_not_empty;

  // Acceptance depends only on the registered count, so it never combinationally follows a pop.
  assign readyForData = (r_count != FULL_CNT);
  assign w_push       = dataValid && readyForData;
  assign w_not_empty  = (r_count != '0);
  assign serialOut    = r_serial;
  assign busy         = (r_state != S_IDLE) || w_not_empty;
  assign fifoCount    = r_count;

  // FIFO storage is written only on the accepting edge; contents need no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame state register; reset truncates any frame and returns the line high at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_serial <= w_serial_nxt;
    end
  end

  // Next-state logic: each bit holds TICKS_PER_CYCLE+1 clocks; STOP chains straight into the next start bit.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_serial_nxt = r_serial;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_serial_nxt = 1'b1;
        if (w_not_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = r_mem[r_rd_ptr];
          w_serial_nxt = 1'b0;
          w_tick_nxt   = TICK_RELOAD;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (r_tick != '0) begin
          w_tick_nxt = r_tick - 1'b1;
        end else begin
          w_serial_nxt = r_shift[0];
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_bit_nxt    = 3'd7;
          w_tick_nxt   = TICK_RELOAD;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (r_tick != '0) begin
          w_tick_nxt = r_tick - 1'b1;
        end else if (r_bit != 3'd0) begin
          w_serial_nxt = r_shift[0];
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_bit_nxt    = r_bit - 1'b1;
          w_tick_nxt   = TICK_RELOAD;
        end else begin
          w_serial_nxt = 1'b1;
          w_tick_nxt   = TICK_RELOAD;
          w_state_nxt  = S_STOP;
        end
      end
      S_STOP: begin
        if (r_tick != '0) begin
          w_tick_nxt = r_tick - 1'b1;
        end else if (w_not_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = r_mem[r_rd_ptr];
          w_serial_nxt = 1'b0;
          w_tick_nxt   = TICK_RELOAD;
          w_state_nxt  = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_serial_nxt = 1'b1;
      end
    endcase
  end

endmodule
